// File: rtl/generic_sync_fifo.sv
// Single-clock FIFO with occupancy count, almost flags, sticky ovf/udf and synchronous flush.
// Define GENERIC_SYNC_FIFO_FWFT_EN for first-word-fall-through; read data port is dout (do is reserved).
module generic_sync_fifo #(
  parameter int unsigned aw         = 4,
  parameter int unsigned dw         = 8,
  parameter int unsigned afull_lvl  = (1 << aw) - 1,
  parameter int unsigned aempty_lvl = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          ce,
  input  logic          clr,
  input  logic          wr_en,
  input  logic [dw-1:0] di,
  input  logic          rd_en,
  output logic [dw-1:0] dout,
  output logic          do_vld,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          almost_empty,
  output logic [aw:0]   count,
  output logic          ovf,
  output logic          udf
);

  localparam int unsigned Depth   = 1 << aw;
  localparam logic [aw:0] DepthC  = (aw+1)'(Depth);
  localparam logic [aw:0] AfullC  = (aw+1)'(afull_lvl);
  localparam logic [aw:0] AemptyC = (aw+1)'(aempty_lvl);

  logic [dw-1:0] mem_q [Depth];

  logic [aw-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [aw:0]   count_q, count_d;
  logic [dw-1:0] dout_q, dout_d;
  logic          do_vld_q, do_vld_d;
  logic          ovf_q, ovf_d, udf_q, udf_d;
  logic          wa, ra, rd_fetch;

  always_comb begin
    full         = (count_q == DepthC);
    almost_full  = (count_q >= AfullC);
    almost_empty = (count_q <= AemptyC);
`ifdef GENERIC_SYNC_FIFO_FWFT_EN
    empty        = ~do_vld_q;
`else
    empty        = (count_q == '0);
`endif
  end

`ifdef GENERIC_SYNC_FIFO_FWFT_EN
  logic [aw:0] ram_cnt;
  always_comb begin
    wa       = ce & wr_en & ~full;
    ra       = ce & rd_en & do_vld_q;
    // count includes the word held in dout, so the RAM holds one fewer while it is valid
    ram_cnt  = count_q - {{aw{1'b0}}, do_vld_q};
    rd_fetch = ce & (ram_cnt != '0) & (~do_vld_q | ra);
  end
`else
  always_comb begin
    wa       = ce & wr_en & ~full;
    ra       = ce & rd_en & ~empty;
    rd_fetch = ra;
  end
`endif

  always_comb begin
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    dout_d   = dout_q;
    do_vld_d = do_vld_q;
    ovf_d    = ovf_q;
    udf_d    = udf_q;
    if (clr) begin
      wptr_d   = '0;
      rptr_d   = '0;
      count_d  = '0;
      do_vld_d = 1'b0;
      ovf_d    = 1'b0;
      udf_d    = 1'b0;
    end else begin
      if (wa) wptr_d = wptr_q + aw'(1);
      if (rd_fetch) begin
        rptr_d = rptr_q + aw'(1);
        dout_d = mem_q[rptr_q];
      end
      unique case ({wa, ra})
        2'b10:   count_d = count_q + (aw+1)'(1);
        2'b01:   count_d = count_q - (aw+1)'(1);
        default: count_d = count_q;
      endcase
`ifdef GENERIC_SYNC_FIFO_FWFT_EN
      if (ce & (ra | ~do_vld_q)) do_vld_d = rd_fetch;
`else
      do_vld_d = ra;
`endif
      ovf_d = ovf_q | (ce & wr_en & full);
      // A concurrent accepted write turns an empty-read into a wait, not an underflow
      udf_d = udf_q | (ce & rd_en & empty & ~wa);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      dout_q   <= '0;
      do_vld_q <= 1'b0;
      ovf_q    <= 1'b0;
      udf_q    <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      dout_q   <= dout_d;
      do_vld_q <= do_vld_d;
      ovf_q    <= ovf_d;
      udf_q    <= udf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !clr && wa) mem_q[wptr_q] <= di;
  end

  assign dout   = dout_q;
  assign do_vld = do_vld_q;
  assign count  = count_q;
  assign ovf    = ovf_q;
  assign udf    = udf_q;

endmodule
